// File: rtl/adc_spi_seq.sv
`default_nettype none
// ============================================================================
// Module   : adc_spi_seq
// Brief    : ADS4128 serial-port sequencer (16-bit write/read) and ADC reset pulse
// Revision : 1.0 - initial release
// ============================================================================
module adc_spi_seq #(
  parameter int pHALF     = 4,
  parameter int pRST_HI   = 16,
  parameter int pRST_WAIT = 64
) (
  input  logic       clk_usb,
  input  logic       reset_n,
  input  logic       cmd_start,
  input  logic       cmd_read,
  input  logic [7:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  input  logic       rst_req,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       ADC_SEN,
  output logic       ADC_SCLK,
  output logic       ADC_SDATA,
  output logic       ADC_RESET,
  input  logic       ADC_OVR_SDOUT
);

  localparam int c_MAXD = (pHALF > pRST_HI)
                        ? ((pHALF > pRST_WAIT) ? pHALF : pRST_WAIT)
                        : ((pRST_HI > pRST_WAIT) ? pRST_HI : pRST_WAIT);
  localparam int c_PW = $clog2(c_MAXD) + 1;

  localparam logic [2:0] c_IDLE      = 3'd0;
  localparam logic [2:0] c_SETUP     = 3'd1;
  localparam logic [2:0] c_BIT_HI    = 3'd2;
  localparam logic [2:0] c_BIT_LO    = 3'd3;
  localparam logic [2:0] c_HOLD      = 3'd4;
  localparam logic [2:0] c_RST_PULSE = 3'd5;
  localparam logic [2:0] c_RST_WAIT  = 3'd6;

  logic [2:0]      r_state, w_state_nxt;
  logic [c_PW-1:0] r_phase, w_phase_nxt, w_dur_m1;
  logic [3:0]      r_bitcnt, w_bitcnt_nxt;
  logic [15:0]     r_shift, w_shift_nxt;
  logic            r_is_read, w_is_read_nxt;
  logic [7:0]      r_rd_shift, w_rd_shift_nxt;
  logic [7:0]      r_rdata, w_rdata_nxt;
  logic            w_last;
  logic            w_serial;

  logic r_busy, r_done, r_sen, r_sclk, r_sdata, r_adc_rst;
  logic w_busy, w_done, w_sen, w_sclk, w_sdata, w_adc_rst;

  // State register and datapath registers
  always_ff @(posedge clk_usb or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= c_IDLE;
      r_phase    <= '0;
      r_bitcnt   <= '0;
      r_shift    <= '0;
      r_is_read  <= 1'b0;
      r_rd_shift <= '0;
      r_rdata    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_phase    <= w_phase_nxt;
      r_bitcnt   <= w_bitcnt_nxt;
      r_shift    <= w_shift_nxt;
      r_is_read  <= w_is_read_nxt;
      r_rd_shift <= w_rd_shift_nxt;
      r_rdata    <= w_rdata_nxt;
    end
  end

  always_comb begin
    w_dur_m1 = '0;
    case (r_state)
      c_SETUP, c_BIT_HI, c_BIT_LO, c_HOLD: w_dur_m1 = c_PW'(pHALF - 1);
      c_RST_PULSE:                         w_dur_m1 = c_PW'(pRST_HI - 1);
      c_RST_WAIT:                          w_dur_m1 = c_PW'(pRST_WAIT - 1);
      default:                             w_dur_m1 = '0;
    endcase
  end

  assign w_last = (r_phase == w_dur_m1);

  // Next-state logic; every non-IDLE state is timed by r_phase
  always_comb begin
    w_state_nxt    = r_state;
    w_phase_nxt    = r_phase;
    w_bitcnt_nxt   = r_bitcnt;
    w_shift_nxt    = r_shift;
    w_is_read_nxt  = r_is_read;
    w_rd_shift_nxt = r_rd_shift;
    w_rdata_nxt    = r_rdata;

    if (r_state != c_IDLE)
      w_phase_nxt = w_last ? '0 : (r_phase + c_PW'(1));

    case (r_state)
      c_IDLE: begin
        w_phase_nxt = '0;
        if (rst_req) begin
          w_state_nxt = c_RST_PULSE;
        end else if (cmd_start) begin
          w_shift_nxt   = cmd_read ? {cmd_addr, 8'h00} : {cmd_addr, cmd_wdata};
          w_is_read_nxt = cmd_read;
          w_bitcnt_nxt  = 4'd15;
          w_state_nxt   = c_SETUP;
        end
      end
      c_SETUP:  if (w_last) w_state_nxt = c_BIT_HI;
      c_BIT_HI: if (w_last) w_state_nxt = c_BIT_LO;
      c_BIT_LO: begin
        if (w_last) begin
          // Readback bit is taken just before SCLK rises again
          if (r_is_read && (r_bitcnt <= 4'd7))
            w_rd_shift_nxt = {r_rd_shift[6:0], ADC_OVR_SDOUT};
          if (r_bitcnt == 4'd0) begin
            w_state_nxt = c_HOLD;
          end else begin
            w_bitcnt_nxt = r_bitcnt - 4'd1;
            w_state_nxt  = c_BIT_HI;
          end
        end
      end
      c_HOLD: begin
        if (w_last) begin
          w_state_nxt = c_IDLE;
          if (r_is_read)
            w_rdata_nxt = r_rd_shift;
        end
      end
      c_RST_PULSE: if (w_last) w_state_nxt = c_RST_WAIT;
      c_RST_WAIT:  if (w_last) w_state_nxt = c_IDLE;
      default:     w_state_nxt = c_IDLE;
    endcase
  end

  // Pin values are decoded from the next state so the registered pins line up with it
  always_comb begin
    w_serial  = (w_state_nxt == c_SETUP) || (w_state_nxt == c_BIT_HI) ||
                (w_state_nxt == c_BIT_LO) || (w_state_nxt == c_HOLD);
    w_busy    = (w_state_nxt != c_IDLE);
    w_done    = ((r_state == c_HOLD) || (r_state == c_RST_WAIT)) && w_last;
    w_sen     = !w_serial;
    w_sclk    = (w_state_nxt != c_BIT_LO);
    w_sdata   = w_serial ? w_shift_nxt[w_bitcnt_nxt] : 1'b0;
    w_adc_rst = (w_state_nxt == c_RST_PULSE);
  end

  always_ff @(posedge clk_usb or negedge reset_n) begin
    if (!reset_n) begin
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_sen     <= 1'b1;
      r_sclk    <= 1'b1;
      r_sdata   <= 1'b0;
      r_adc_rst <= 1'b0;
    end else begin
      r_busy    <= w_busy;
      r_done    <= w_done;
      r_sen     <= w_sen;
      r_sclk    <= w_sclk;
      r_sdata   <= w_sdata;
      r_adc_rst <= w_adc_rst;
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign rdata     = r_rdata;
  assign ADC_SEN   = r_sen;
  assign ADC_SCLK  = r_sclk;
  assign ADC_SDATA = r_sdata;
  assign ADC_RESET = r_adc_rst;

endmodule
`default_nettype wire

// File: doc/adc_spi_seq.md
Name: adc_spi_seq

Overview:
- Hardware serial-interface sequencer for the ADS4128 ADC configuration port.
- Replaces per-edge bit-banging of SEN/SCLK/SDATA: one command runs a complete 16-bit register write or read transaction.
- Also generates a timed ADC_RESET pulse.
- Sits between the clk_usb register block, which drives cmd_*/rst_req and reads rdata/status, and the ADC control pins.

Parameters:
pHALF, 4, SCLK half-period in clk_usb cycles (>=2); SCLK period = 2*pHALF.
pRST_HI, 16, ADC_RESET high duration in clk_usb cycles (>=1).
pRST_WAIT, 64, post-reset wait in clk_usb cycles before accepting commands (>=1).

Ports:
clk_usb  in  1  system clock; all logic on rising edge.
reset_n  in  1  asynchronous, active-low reset.
cmd_start  in  1  single-cycle request; sampled only in IDLE.
cmd_read  in  1  1=read transaction, 0=write; sampled with cmd_start.
cmd_addr  in  8  ADC register address; sampled with cmd_start.
cmd_wdata  in  8  write data; sampled with cmd_start, ignored on read.
rst_req  in  1  single-cycle request for an ADC hardware reset pulse.
busy  out  1  high from the cycle after acceptance until done.
done  out  1  one-cycle pulse at the end of each transaction or reset sequence.
rdata  out  8  last read byte; holds until the next read completes.
ADC_SEN  out  1  serial enable, active low.
ADC_SCLK  out  1  serial clock, idles high.
ADC_SDATA  out  1  serial data to ADC.
ADC_RESET  out  1  ADC hardware reset, active high.
ADC_OVR_SDOUT  in  1  serial readback from ADC.

Behaviour:
- Reset (async assert, synchronous release): state=IDLE, busy=0, done=0, rdata=0, ADC_SEN=1, ADC_SCLK=1, ADC_SDATA=0, ADC_RESET=0, all counters 0.
- Outputs are registered, with no combinational path from inputs to pins.
- States: IDLE, SETUP, BIT_HI, BIT_LO, HOLD, RST_PULSE, RST_WAIT. Timed states last exactly their stated duration, counted by a phase counter.
- IDLE:
  - rst_req=1 -> RST_PULSE; this takes priority over a simultaneous cmd_start, which is dropped.
  - else cmd_start=1 -> latch shift={cmd_addr,cmd_wdata} (or {cmd_addr,8'h00} when cmd_read), latch the read flag, bit counter=15, go to SETUP.
  - busy=1 from the next cycle.
- SETUP (pHALF cycles): SEN=0, SCLK=1, SDATA=shift[15].
- BIT_HI (pHALF cycles): SCLK=1, SDATA=shift[bitcnt]. ADC latches SDATA on the following falling edge.
- BIT_LO (pHALF cycles): SCLK=0, SDATA held.
  - On the last cycle of BIT_LO, when read and bitcnt<=7: rd_shift <= {rd_shift[6:0], ADC_OVR_SDOUT}.
  - Then bitcnt=0 -> HOLD, else bitcnt-1 -> BIT_HI.
- HOLD (pHALF cycles): SCLK=1, SEN=0. Exit -> IDLE with SEN=1, busy=0, done=1 for one cycle. On read, rdata <= rd_shift in that same cycle.
- Transaction length: busy high for exactly 34*pHALF cycles (SETUP + 16 bit periods + HOLD).
- RST_PULSE: ADC_RESET=1 for pRST_HI cycles, then RST_WAIT with ADC_RESET=0 for pRST_WAIT cycles, then IDLE with done=1. busy=1 throughout; SEN=1 and SCLK=1 throughout.
- cmd_start or rst_req while busy: ignored, not queued.
- rst_req arriving during a transaction is also ignored.
- reset_n asserted mid-transaction or mid-pulse: outputs return to reset values immediately. Any partial transfer is abandoned; ADC ignores it because SEN deasserts.
- rdata is unchanged by write transactions and by reset sequences. It is cleared only by reset_n.
- Read mode requires the ADC READOUT bit set first (register 0x00, bit 0). That is a separate write command; the block does not insert it.

Test Plan:
- Write addr 0x55, data 0xAA, pHALF=4:
  - SDATA sampled at each SCLK falling edge = 0101_0101_1010_1010 MSB first.
  - Exactly 16 falling edges while SEN=0.
  - busy high for 136 cycles, then one done pulse; rdata stays 0x00.
- Read addr 0x55 with a bench ADC model driving SDOUT=0xC3 on the falling edges of bits 7..0:
  - Address bits are 0101_0101 followed by 8 zeros.
  - rdata=0xC3 in the done cycle and held afterwards.
- Issue a write, then 10 cycles later cmd_start (read) and rst_req:
  - Both ignored; only one done pulse.
  - Bit pattern unchanged; rdata unchanged.
- rst_req and cmd_start in the same IDLE cycle:
  - ADC_RESET high exactly 16 cycles, SEN stays 1.
  - done after 80 cycles; no serial activity.
- reset_n low during bit 9 of a write:
  - Same cycle: SEN=1, SCLK=1, SDATA=0, busy=0.
  - After release, a new write to 0x01/0x02 completes normally with the correct bits.
- Back-to-back: cmd_start in the cycle immediately after done:
  - Accepted; SEN returns low the next cycle.
  - Second transaction bits correct; SEN is high for exactly 1 cycle between transactions.
